// File: rtl/calendar_date_counter.sv
// ---------------------------------------------------------------------------
// calendar_date_counter
// Date-keeping block of the electric clock. Holds year/month/day as BCD,
// advances one day per carry from the time-of-day counter and accepts
// manual set-increments from debounced keys. Full Gregorian calendar.
//
// Ports:
//   Clk        in   1   system clock, rising edge
//   Reset_n    in   1   synchronous active-low reset (loads RESET_*)
//   cnt_inc    in   3   manual increments: [0] day, [1] month, [2] year
//   full_flag  in   1   day carry from the time counter
//   Data       out  32  BCD date YYYYMMDD: [31:16] year, [15:8] month, [7:0] day
//
// Priority per cycle: reset > full_flag > cnt_inc[2] > cnt_inc[1] > cnt_inc[0].
// ---------------------------------------------------------------------------
module calendar_date_counter #(
    parameter logic [15:0] RESET_YEAR  = 16'h2025,
    parameter logic [7:0]  RESET_MONTH = 8'h01,
    parameter logic [7:0]  RESET_DAY   = 8'h01
) (
    input  logic        Clk,
    input  logic        Reset_n,
    input  logic [2:0]  cnt_inc,
    input  logic        full_flag,
    output logic [31:0] Data
);

    localparam int unsigned YEAR_W = 16;
    localparam int unsigned MD_W   = 8;

    logic [YEAR_W-1:0] r_year;
    logic [MD_W-1:0]   r_month;
    logic [MD_W-1:0]   r_day;

    logic [YEAR_W-1:0] w_year_nxt;
    logic [MD_W-1:0]   w_month_nxt;
    logic [MD_W-1:0]   w_day_nxt;

    logic [YEAR_W-1:0] w_year_inc;
    logic [MD_W-1:0]   w_month_inc;
    logic [MD_W-1:0]   w_day_inc;
    logic [MD_W-1:0]   w_dim_cur;
    logic [MD_W-1:0]   w_dim_new_year;
    logic [MD_W-1:0]   w_dim_new_month;

    // Two-digit BCD increment (callers never pass 99).
    function automatic logic [7:0] inc_bcd2(input logic [7:0] v);
        logic [7:0] r;
        if (v[3:0] == 4'd9) begin
            r = {4'(v[7:4] + 4'd1), 4'd0};
        end else begin
            r = {v[7:4], 4'(v[3:0] + 4'd1)};
        end
        return r;
    endfunction

    // Four-digit BCD increment with decimal ripple; 9999 wraps to 0000.
    function automatic logic [15:0] inc_bcd4(input logic [15:0] v);
        logic [15:0] r;
        logic        carry;
        r     = v;
        carry = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (carry) begin
                if (r[i*4 +: 4] == 4'd9) begin
                    r[i*4 +: 4] = 4'd0;
                end else begin
                    r[i*4 +: 4] = 4'(r[i*4 +: 4] + 4'd1);
                    carry       = 1'b0;
                end
            end
        end
        return r;
    endfunction

    // Two BCD digits divisible by 4: 10*t + u == 2*t[0] + u (mod 4).
    function automatic logic bcd2_mod4_zero(input logic [7:0] v);
        logic [1:0] s;
        s = 2'({v[4], 1'b0} + v[1:0]);
        return (s == 2'd0);
    endfunction

    // Gregorian leap rule evaluated directly on the BCD digits.
    function automatic logic is_leap(input logic [15:0] y);
        logic leap;
        if (y[7:0] != 8'h00) begin
            leap = bcd2_mod4_zero(y[7:0]);
        end else begin
            leap = bcd2_mod4_zero(y[15:8]);
        end
        return leap;
    endfunction

    // Month length in BCD.
    function automatic logic [7:0] days_in_month(input logic [7:0] m, input logic leap);
        logic [7:0] d;
        case (m)
            8'h02:                      d = leap ? 8'h29 : 8'h28;
            8'h04, 8'h06, 8'h09, 8'h11: d = 8'h30;
            default:                    d = 8'h31;
        endcase
        return d;
    endfunction

    // Candidate values shared by the different actions.
    assign w_year_inc      = inc_bcd4(r_year);
    assign w_month_inc     = (r_month == 8'h12) ? 8'h01 : inc_bcd2(r_month);
    assign w_day_inc       = inc_bcd2(r_day);
    assign w_dim_cur       = days_in_month(r_month, is_leap(r_year));
    assign w_dim_new_year  = days_in_month(r_month, is_leap(w_year_inc));
    assign w_dim_new_month = days_in_month(w_month_inc, is_leap(r_year));

    // Next-date selection; BCD compares as unsigned since digits stay 0..9.
    always_comb begin
        w_year_nxt  = r_year;
        w_month_nxt = r_month;
        w_day_nxt   = r_day;
        if (full_flag) begin
            if (r_day < w_dim_cur) begin
                w_day_nxt = w_day_inc;
            end else begin
                w_day_nxt   = 8'h01;
                w_month_nxt = w_month_inc;
                if (r_month == 8'h12) begin
                    w_year_nxt = w_year_inc;
                end
            end
        end else if (cnt_inc[2]) begin
            w_year_nxt = w_year_inc;
            if (r_day > w_dim_new_year) begin
                w_day_nxt = w_dim_new_year;
            end
        end else if (cnt_inc[1]) begin
            w_month_nxt = w_month_inc;
            if (r_day > w_dim_new_month) begin
                w_day_nxt = w_dim_new_month;
            end
        end else if (cnt_inc[0]) begin
            w_day_nxt = (r_day >= w_dim_cur) ? 8'h01 : w_day_inc;
        end
    end

    // Date registers.
    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            r_year  <= RESET_YEAR;
            r_month <= RESET_MONTH;
            r_day   <= RESET_DAY;
        end else begin
            r_year  <= w_year_nxt;
            r_month <= w_month_nxt;
            r_day   <= w_day_nxt;
        end
    end

    assign Data = {r_year, r_month, r_day};

endmodule

// File: tb/tb_calendar_date_counter.sv
// ---------------------------------------------------------------------------
// tb_calendar_date_counter
// Directed bench for calendar_date_counter. Inputs change 1 time unit after
// a rising edge and Data is sampled 1 time unit after the next rising edge.
// ---------------------------------------------------------------------------
module tb_calendar_date_counter;

    logic        Clk;
    logic        Reset_n;
    logic [2:0]  cnt_inc;
    logic        full_flag;
    logic [31:0] Data;

    int total = 0;
    int bad   = 0;

    calendar_date_counter dut (
        .Clk       (Clk),
        .Reset_n   (Reset_n),
        .cnt_inc   (cnt_inc),
        .full_flag (full_flag),
        .Data      (Data)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    // Advance n rising edges, then settle 1 unit past the last edge.
    task automatic tick(input int n);
        repeat (n) @(posedge Clk);
        #1;
    endtask

    // Hold the given enables for n cycles, then release them.
    task automatic apply(input logic ff, input logic [2:0] inc, input int n);
        full_flag = ff;
        cnt_inc   = inc;
        tick(n);
        full_flag = 1'b0;
        cnt_inc   = 3'b000;
    endtask

    task automatic do_reset();
        Reset_n = 1'b0;
        tick(1);
        Reset_n = 1'b1;
    endtask

    task automatic check(input string tag, input logic [31:0] exp);
        total++;
        assert (Data === exp)
        else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, Data, exp);
        end
    endtask

    initial begin
        Reset_n   = 1'b0;
        cnt_inc   = 3'b000;
        full_flag = 1'b0;
        #1;

        // Reset and idle hold
        tick(10);
        check("reset", 32'h20250101);
        Reset_n = 1'b1;
        tick(5);
        check("idle_hold", 32'h20250101);

        // Bulk advance of 2000 days
        apply(1'b1, 3'b000, 2000);
        check("bulk_2000", 32'h20300624);
        tick(5);
        check("bulk_stable", 32'h20300624);

        // Jan 31 -> Feb 1
        do_reset();
        apply(1'b1, 3'b000, 30);
        check("jan31", 32'h20250131);
        apply(1'b1, 3'b000, 1);
        check("jan31_to_feb1", 32'h20250201);

        // Leap 2028: Feb 28 -> 29 -> Mar 1
        do_reset();
        apply(1'b0, 3'b100, 3);
        apply(1'b0, 3'b010, 1);
        apply(1'b0, 3'b001, 27);
        check("setup_2028_0228", 32'h20280228);
        apply(1'b1, 3'b000, 1);
        check("leap_2028_feb29", 32'h20280229);
        apply(1'b1, 3'b000, 1);
        check("leap_2028_mar1", 32'h20280301);

        // Year step from Feb 29 clamps to Feb 28
        do_reset();
        apply(1'b0, 3'b100, 3);
        apply(1'b0, 3'b010, 1);
        apply(1'b0, 3'b001, 28);
        check("setup_2028_0229", 32'h20280229);
        apply(1'b0, 3'b100, 1);
        check("year_clamp_feb29", 32'h20290228);

        // Century non-leap 2100
        do_reset();
        apply(1'b0, 3'b100, 75);
        apply(1'b0, 3'b010, 1);
        apply(1'b0, 3'b001, 27);
        check("setup_2100_0228", 32'h21000228);
        apply(1'b1, 3'b000, 1);
        check("nonleap_2100", 32'h21000301);

        // 9999-12-31 wraps to 0000-01-01
        do_reset();
        apply(1'b0, 3'b100, 7974);
        check("year_9999", 32'h99990101);
        apply(1'b0, 3'b010, 11);
        apply(1'b0, 3'b001, 30);
        check("setup_99991231", 32'h99991231);
        apply(1'b1, 3'b000, 1);
        check("wrap_9999", 32'h00000101);

        // Leap 2000 (reached from 0000)
        apply(1'b0, 3'b100, 2000);
        apply(1'b0, 3'b010, 1);
        apply(1'b0, 3'b001, 27);
        check("setup_2000_0228", 32'h20000228);
        apply(1'b1, 3'b000, 1);
        check("leap_2000", 32'h20000229);

        // Manual day wraps without month carry
        do_reset();
        apply(1'b0, 3'b010, 3);
        apply(1'b0, 3'b001, 29);
        check("setup_0430", 32'h20250430);
        apply(1'b0, 3'b001, 1);
        check("day_wrap", 32'h20250401);

        // Manual month wraps without year carry
        do_reset();
        apply(1'b0, 3'b010, 11);
        apply(1'b0, 3'b001, 14);
        check("setup_1215", 32'h20251215);
        apply(1'b0, 3'b010, 1);
        check("month_wrap", 32'h20250115);

        // Manual month clamps day
        do_reset();
        apply(1'b0, 3'b010, 2);
        apply(1'b0, 3'b001, 30);
        check("setup_0331", 32'h20250331);
        apply(1'b0, 3'b010, 1);
        check("month_clamp", 32'h20250430);

        // Year held 100 cycles
        do_reset();
        apply(1'b0, 3'b100, 100);
        check("year_x100", 32'h21250101);

        // full_flag beats all manual increments
        do_reset();
        apply(1'b1, 3'b000, 30);
        apply(1'b1, 3'b111, 1);
        check("prio_full", 32'h20250201);

        // Month beats day
        do_reset();
        apply(1'b0, 3'b001, 9);
        check("setup_0110", 32'h20250110);
        apply(1'b0, 3'b011, 1);
        check("prio_month", 32'h20250210);

        // Reset beats full_flag
        apply(1'b1, 3'b000, 3);
        check("pre_reset", 32'h20250213);
        Reset_n   = 1'b0;
        full_flag = 1'b1;
        tick(1);
        check("prio_reset", 32'h20250101);
        full_flag = 1'b0;
        Reset_n   = 1'b1;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/calendar_date_counter.md
Name: calendar_date_counter

Overview:
- Date-keeping block of the electric clock: holds year/month/day as BCD and advances one day per carry from the time-of-day counter.
- Accepts manual set-increments for day, month and year from debounced keys.
- Drives a packed 32-bit BCD word, YYYYMMDD, to the display mux.
- Full Gregorian month-length and leap-year rules.

Parameters:
- RESET_YEAR, 16'h2025, 4-digit BCD year loaded on reset.
- RESET_MONTH, 8'h01, 2-digit BCD month loaded on reset (01..12).
- RESET_DAY, 8'h01, 2-digit BCD day loaded on reset; must be valid for RESET_MONTH/RESET_YEAR.

Ports:
- Clk  input  1  system clock; all state updates on its rising edge.
- Reset_n  input  1  synchronous, active-low reset.
- cnt_inc  input  3  manual increment enables: bit0 = day, bit1 = month, bit2 = year.
- full_flag  input  1  day-carry enable from the time counter (23:59:59 rollover).
- Data  output  32  BCD date: [31:16] year (4 digits), [15:8] month, [7:0] day.

Behaviour:
- Single clock domain. Reset is synchronous and active-low: when Reset_n=0 at a rising edge, year/month/day load the RESET_* values. Data = 32'h20250101 with defaults.
- Data is the direct concatenation of the year/month/day registers. It is valid the same cycle the registers update; no extra latency.
- All enables are level-sensitive: one action per rising edge for every cycle the enable is high. Holding for N cycles gives N increments.
- Priority per cycle: Reset_n=0 > full_flag > cnt_inc[2] > cnt_inc[1] > cnt_inc[0]. Only one action is applied per cycle.
- full_flag (auto advance):
  - If day < days_in_month: day+1.
  - Else day=01 and month+1.
  - If month was 12: month=01 and year+1.
  - Year 9999 wraps to 0000.
- cnt_inc[0] (set day): day+1; day at days_in_month wraps to 01. No carry into month.
- cnt_inc[1] (set month): month+1; 12 wraps to 01. No carry into year. If day > days_in_month of the new month, day clamps to that maximum.
- cnt_inc[2] (set year): year+1; 9999 wraps to 0000. Clamp day to the new month length (29 Feb -> 28 Feb in a non-leap year).
- days_in_month:
  - 31 for 01,03,05,07,08,10,12.
  - 30 for 04,06,09,11.
  - Feb: 29 if leap, else 28.
- Leap year, computed on BCD digits:
  - Low two digits != 00: leap when (low two digits mod 4)=0.
  - Low two digits == 00: leap when (high two digits mod 4)=0.
  - So 2000 and 0000 are leap; 2100 is not.
- All arithmetic is per-digit BCD with decimal carry. Digits never hold A..F.
- Reset asserted mid-run overrides any enable in the same cycle.
- Register values are only ever valid dates, given valid RESET_* values.

Test Plan:
- Reset: Reset_n=0 for 10 cycles, then release -> Data=32'h20250101. It holds with all inputs 0.
- Bulk advance: from reset, full_flag high for exactly 2000 cycles -> Data=32'h20300624. Data is stable afterwards.
- Month/year and leap boundaries via full_flag single pulses:
  - 2025-01-31 -> 2025-02-01.
  - 2028-02-28 -> 2028-02-29 -> 2028-03-01.
  - 2100-02-28 -> 2100-03-01.
  - 2000-02-28 -> 2000-02-29.
  - 9999-12-31 -> 32'h00000101.
- Manual day/month:
  - cnt_inc=001 at 2025-04-30 -> 2025-04-01 (no month carry).
  - cnt_inc=010 at 2025-12-15 -> 2025-01-15 (no year carry).
  - cnt_inc=010 at 2025-03-31 -> 2025-04-30 (clamp).
- Manual year: cnt_inc=100 at 2028-02-29 -> 2029-02-28. Held for 100 cycles from 2025-01-01 -> 2125-01-01.
- Priority/reset:
  - full_flag=1 with cnt_inc=111 at 2025-01-31 -> 2025-02-01 only.
  - cnt_inc=011 at 2025-01-10 -> 2025-02-10 only.
  - Reset_n=0 with full_flag=1 -> 32'h20250101.
